// File: rtl/eth_axis_to_avst_tx_bridge.sv
// ============================================================================
// eth_axis_to_avst_tx_bridge
//
// Buffered AXI-Stream to Avalon-ST bridge for the Ethernet TX path. It sits
// between the AFU-facing AXI-S TX stream and the MAC's AVST TX port.
//
// Each accepted beat is converted before it enters a small beat FIFO:
//   - byte order reversed (AXI-S byte 0 in [7:0] -> AVST byte 0 in MSBs)
//   - tkeep turned into an AVST empty count (last beat only)
//   - sop generated from packet state
//   - malformed tkeep detected and folded into a per-packet error flag
// The FIFO decouples the AFU from MAC backpressure and supports a MAC ready
// latency of 0 or 1.
//
// Parameters:
//   DATA_WIDTH    bus width in bits, multiple of 8 (64..1024)
//   USER_WIDTH    width of the sideband user field (carried unmodified)
//   FIFO_DEPTH    beat buffer entries, power of 2, >= 2
//   READY_LATENCY MAC ready latency, 0 or 1
//
// Ports:
//   clk, rst_n           single clock, synchronous active-low reset
//   axis_t*              AXI-S slave side (valid/ready/data/keep/last/user)
//   avst_*               AVST source side (valid/ready/sop/eop/data/empty/
//                        user/error); error is meaningful on eop beats only
//   malformed_pulse      one-cycle pulse per accepted malformed beat
//   stat_pkt_cnt         (stats build) eop beats delivered to the MAC, wraps
//   stat_malformed_cnt   (stats build) malformed beats accepted, saturates
//
// Build option: define ETH_AXIS_AVST_BRIDGE_STATS_EN to add the statistics
// counters and their ports. Without it the ports and counters do not exist.
//
// SOP state machine:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   SOP_WAIT | next accepted beat starts a packet (sop=1)
//   IN_PKT   | inside a multi-beat packet, waiting for the tlast beat
// ============================================================================
module eth_axis_to_avst_tx_bridge #(
    parameter int DATA_WIDTH    = 64,
    parameter int USER_WIDTH    = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int READY_LATENCY = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic                               axis_tvalid,
    output logic                               axis_tready,
    input  logic [DATA_WIDTH-1:0]              axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]            axis_tkeep,
    input  logic                               axis_tlast,
    input  logic [USER_WIDTH-1:0]              axis_tuser,

    output logic                               avst_valid,
    input  logic                               avst_ready,
    output logic                               avst_sop,
    output logic                               avst_eop,
    output logic [DATA_WIDTH-1:0]              avst_data,
    output logic [$clog2(DATA_WIDTH/8)-1:0]    avst_empty,
    output logic [USER_WIDTH-1:0]              avst_user,
    output logic                               avst_error,

    output logic                               malformed_pulse
`ifdef ETH_AXIS_AVST_BRIDGE_STATS_EN
    ,
    output logic [31:0]                        stat_pkt_cnt,
    output logic [15:0]                        stat_malformed_cnt
`endif
);

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int EMPTY_W = $clog2(BYTES);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_WIDTH + EMPTY_W + 3 + USER_WIDTH;

    // Field offsets inside one FIFO entry (LSB first).
    localparam int OFS_EMPTY = DATA_WIDTH;
    localparam int OFS_SOP   = OFS_EMPTY + EMPTY_W;
    localparam int OFS_EOP   = OFS_SOP + 1;
    localparam int OFS_ERR   = OFS_EOP + 1;
    localparam int OFS_USER  = OFS_ERR + 1;

    localparam logic [AW:0]         FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]         CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]       PTR_ONE   = AW'(1);
    localparam logic [EMPTY_W-1:0]  EMPTY_ONE = EMPTY_W'(1);
    localparam logic [EMPTY_W-1:0]  EMPTY_MAX = EMPTY_W'(BYTES - 1);
    localparam logic [BYTES-1:0]    KEEP_ONE  = BYTES'(1);

    localparam logic [0:0] SOP_WAIT = 1'b0;
    localparam logic [0:0] IN_PKT   = 1'b1;

    // ------------------------------------------------------------------
    // Per-beat conversion (combinational, on the input side)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] swapped;
    logic [EMPTY_W-1:0]    lead_zeros;
    logic                  seen_one;
    logic [EMPTY_W-1:0]    empty_calc;
    logic [BYTES-1:0]      keep_inc;
    logic                  keep_ones;
    logic                  keep_zero;
    logic                  keep_contig;
    logic                  malformed;
    logic                  sop_calc;
    logic                  error_calc;

    always_comb begin
        swapped = '0;
        for (int b = 0; b < BYTES; b++) begin
            swapped[8*(BYTES-1-b) +: 8] = axis_tdata[8*b +: 8];
        end
    end

    // Leading-zero count of tkeep from the MSB, looking only at bytes
    // BYTES-1..1. Byte 0 never adds to the count, so an all-zero mask
    // lands on BYTES-1 naturally and the count always fits EMPTY_W bits.
    always_comb begin
        lead_zeros = '0;
        seen_one   = 1'b0;
        for (int b = BYTES - 1; b >= 1; b--) begin
            if (axis_tkeep[b]) begin
                seen_one = 1'b1;
            end else if (!seen_one) begin
                lead_zeros = lead_zeros + EMPTY_ONE;
            end
        end
    end

    // A mask of the form 0..01..1 has no overlap with itself plus one
    // (the add carries through the run of ones). All-ones wraps to zero.
    assign keep_inc    = axis_tkeep + KEEP_ONE;
    assign keep_contig = ((keep_inc & axis_tkeep) == '0);
    assign keep_ones   = &axis_tkeep;
    assign keep_zero   = ~|axis_tkeep;

    always_comb begin
        if (axis_tlast) begin
            malformed = keep_zero || !keep_contig;
        end else begin
            malformed = !keep_ones;
        end
    end

    always_comb begin
        if (!axis_tlast) begin
            empty_calc = '0;
        end else if (keep_zero) begin
            empty_calc = EMPTY_MAX;
        end else begin
            empty_calc = lead_zeros;
        end
    end

    logic [0:0] state_q;
    logic       sticky_q;

    assign sop_calc   = (state_q == SOP_WAIT);
    // Error is only carried on the eop beat; earlier beats feed the sticky flag.
    assign error_calc = axis_tlast && (sticky_q || malformed);

    // ------------------------------------------------------------------
    // Beat FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic [AW:0]        count_next;
    logic               tready_q;
    logic               push;
    logic               pop;
    logic               out_valid;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_out;

    assign push      = axis_tvalid && tready_q;
    assign entry_in  = {axis_tuser, error_calc, axis_tlast, sop_calc, empty_calc, swapped};
    assign entry_out = mem[rd_ptr_q];

    always_comb begin
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= entry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            tready_q        <= 1'b0;
            state_q         <= SOP_WAIT;
            sticky_q        <= 1'b0;
            malformed_pulse <= 1'b0;
        end else begin
            count_q         <= count_next;
            // Registered full flag: ready drops in the same cycle the last
            // free slot is taken, so a push can never land on a full FIFO.
            tready_q        <= (count_next != FULL_CNT);
            malformed_pulse <= push && malformed;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end

            if (push) begin
                case (state_q)
                    SOP_WAIT: state_q <= axis_tlast ? SOP_WAIT : IN_PKT;
                    IN_PKT:   state_q <= axis_tlast ? SOP_WAIT : IN_PKT;
                    default:  state_q <= SOP_WAIT;
                endcase

                if (axis_tlast) begin
                    sticky_q <= 1'b0;
                end else if (malformed) begin
                    sticky_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output handshake
    // ------------------------------------------------------------------
    generate
        if (READY_LATENCY == 1) begin : g_rl1
            // With latency 1 the MAC's ready applies to the following cycle,
            // so the beat is presented (and popped) only after a ready=1.
            logic ready_d1;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ready_d1 <= 1'b0;
                end else begin
                    ready_d1 <= avst_ready;
                end
            end

            assign out_valid = ready_d1 && (count_q != '0);
            assign pop       = out_valid;
        end else begin : g_rl0
            assign out_valid = (count_q != '0);
            assign pop       = out_valid && avst_ready;
        end
    endgenerate

    assign axis_tready = tready_q;
    assign avst_valid  = out_valid;

    // Fields are zeroed when nothing is presented so reset leaves every
    // output at 0; while valid they come straight from the FIFO head, which
    // is stable until popped.
    assign avst_data  = out_valid ? entry_out[DATA_WIDTH-1:0]        : '0;
    assign avst_empty = out_valid ? entry_out[OFS_EMPTY +: EMPTY_W]  : '0;
    assign avst_sop   = out_valid && entry_out[OFS_SOP];
    assign avst_eop   = out_valid && entry_out[OFS_EOP];
    assign avst_error = out_valid && entry_out[OFS_ERR];
    assign avst_user  = out_valid ? entry_out[OFS_USER +: USER_WIDTH] : '0;

`ifdef ETH_AXIS_AVST_BRIDGE_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [15:0] mal_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
            mal_cnt_q <= '0;
        end else begin
            if (pop && entry_out[OFS_EOP]) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (push && malformed && (mal_cnt_q != 16'hFFFF)) begin
                mal_cnt_q <= mal_cnt_q + 16'd1;
            end
        end
    end

    assign stat_pkt_cnt       = pkt_cnt_q;
    assign stat_malformed_cnt = mal_cnt_q;
`endif

endmodule

// File: tb/tb_eth_axis_to_avst_tx_bridge.sv
module tb_eth_axis_to_avst_tx_bridge;

    localparam int DW    = 64;
    localparam int EW    = 3;
    localparam int UW    = 1;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
        logic          err;
        logic [UW-1:0] user;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // index 0: READY_LATENCY=0 instance, index 1: READY_LATENCY=1 instance
    logic          axis_tvalid [2];
    logic          axis_tready [2];
    logic [DW-1:0] axis_tdata  [2];
    logic [7:0]    axis_tkeep  [2];
    logic          axis_tlast  [2];
    logic [UW-1:0] axis_tuser  [2];
    logic          avst_valid  [2];
    logic          avst_sop    [2];
    logic          avst_eop    [2];
    logic [DW-1:0] avst_data   [2];
    logic [EW-1:0] avst_empty  [2];
    logic [UW-1:0] avst_user   [2];
    logic          avst_error  [2];
    logic          mal_pulse   [2];
    logic          rdy0 = 1'b0;
    logic          rdy1 = 1'b0;
    logic          rdy1_prev = 1'b0;
    bit            tog_en = 1'b0;
`ifdef ETH_AXIS_AVST_BRIDGE_STATS_EN
    logic [31:0]   stat_pkt [2];
    logic [15:0]   stat_mal [2];
`endif

    eth_axis_to_avst_tx_bridge #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_DEPTH(DEPTH), .READY_LATENCY(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .axis_tvalid(axis_tvalid[0]), .axis_tready(axis_tready[0]),
        .axis_tdata(axis_tdata[0]), .axis_tkeep(axis_tkeep[0]),
        .axis_tlast(axis_tlast[0]), .axis_tuser(axis_tuser[0]),
        .avst_valid(avst_valid[0]), .avst_ready(rdy0),
        .avst_sop(avst_sop[0]), .avst_eop(avst_eop[0]),
        .avst_data(avst_data[0]), .avst_empty(avst_empty[0]),
        .avst_user(avst_user[0]), .avst_error(avst_error[0]),
        .malformed_pulse(mal_pulse[0])
`ifdef ETH_AXIS_AVST_BRIDGE_STATS_EN
        , .stat_pkt_cnt(stat_pkt[0]), .stat_malformed_cnt(stat_mal[0])
`endif
    );

    eth_axis_to_avst_tx_bridge #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_DEPTH(DEPTH), .READY_LATENCY(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .axis_tvalid(axis_tvalid[1]), .axis_tready(axis_tready[1]),
        .axis_tdata(axis_tdata[1]), .axis_tkeep(axis_tkeep[1]),
        .axis_tlast(axis_tlast[1]), .axis_tuser(axis_tuser[1]),
        .avst_valid(avst_valid[1]), .avst_ready(rdy1),
        .avst_sop(avst_sop[1]), .avst_eop(avst_eop[1]),
        .avst_data(avst_data[1]), .avst_empty(avst_empty[1]),
        .avst_user(avst_user[1]), .avst_error(avst_error[1]),
        .malformed_pulse(mal_pulse[1])
`ifdef ETH_AXIS_AVST_BRIDGE_STATS_EN
        , .stat_pkt_cnt(stat_pkt[1]), .stat_malformed_cnt(stat_mal[1])
`endif
    );

    beat_t q0[$];
    beat_t q1[$];
    int vectors     = 0;
    int miscompares = 0;
    int mal_seen0   = 0;
    int mal_seen1   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_beat(input int d);
        beat_t got;
        beat_t exp;
        bit    have;
        got = {avst_data[d], avst_empty[d], avst_sop[d], avst_eop[d], avst_error[d], avst_user[d]};
        vectors++;
        have = 1'b0;
        exp  = '0;
        if (d == 0 && q0.size() != 0) begin
            exp  = q0.pop_front();
            have = 1'b1;
        end else if (d == 1 && q1.size() != 0) begin
            exp  = q1.pop_front();
            have = 1'b1;
        end
        if (!have) begin
            miscompares++;
            $display("FAIL unexpected_beat dut%0d: got data=%h with nothing expected", d, got.data);
        end else if (got !== exp) begin
            miscompares++;
            $display("FAIL beat dut%0d: got data=%h empty=%0d sop=%b eop=%b err=%b user=%b expected data=%h empty=%0d sop=%b eop=%b err=%b user=%b",
                     d, got.data, got.empty, got.sop, got.eop, got.err, got.user,
                     exp.data, exp.empty, exp.sop, exp.eop, exp.err, exp.user);
        end
    endtask

    // Monitor: consumes expected beats whenever a DUT hands one to the MAC.
    always @(negedge clk) begin
        if (avst_valid[0] === 1'b1 && rdy0 === 1'b1) check_beat(0);
        if (avst_valid[1] === 1'b1) begin
            vectors++;
            if (rdy1_prev !== 1'b1) begin
                miscompares++;
                $display("FAIL rl1_valid_without_ready: got valid=1 after ready=%b expected ready=1", rdy1_prev);
            end
            check_beat(1);
        end
        if (mal_pulse[0] === 1'b1) mal_seen0++;
        if (mal_pulse[1] === 1'b1) mal_seen1++;
    end

    always @(posedge clk) rdy1_prev <= rdy1;

    always @(posedge clk) begin
        #1;
        if (tog_en) rdy1 = ~rdy1;
    end

    function automatic logic [63:0] top_byte(input logic [7:0] b);
        return {b, 56'h0};
    endfunction

    task automatic send(input int d, input logic [DW-1:0] data, input logic [7:0] keep,
                        input logic last, input logic [UW-1:0] user,
                        input logic [DW-1:0] exp_data, input logic [EW-1:0] exp_empty,
                        input logic exp_sop, input logic exp_err);
        bit    acc;
        beat_t e;
        acc = 1'b0;
        axis_tvalid[d] = 1'b1;
        axis_tdata[d]  = data;
        axis_tkeep[d]  = keep;
        axis_tlast[d]  = last;
        axis_tuser[d]  = user;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = (axis_tready[d] === 1'b1);
            @(posedge clk);
            #1;
        end
        axis_tvalid[d] = 1'b0;
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL accept_timeout dut%0d: got no tready for data %h expected accept", d, data);
        end else begin
            e = {exp_data, exp_empty, exp_sop, last, exp_err, user};
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("drain_dut%0d_left", d), 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            axis_tvalid[d] = 1'b0;
            axis_tdata[d]  = '0;
            axis_tkeep[d]  = '0;
            axis_tlast[d]  = 1'b0;
            axis_tuser[d]  = '0;
        end
        rdy0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_tready_dut%0d", d), 64'(axis_tready[d]), 64'd0);
            chk($sformatf("rst_valid_dut%0d", d),  64'(avst_valid[d]),  64'd0);
            chk($sformatf("rst_data_dut%0d", d),   avst_data[d],        64'd0);
            chk($sformatf("rst_mal_dut%0d", d),    64'(mal_pulse[d]),   64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single beat, 4 valid bytes
        send(0, 64'h0807060504030201, 8'h0F, 1'b1, 1'b1, 64'h0102030405060708, 3'd4, 1'b1, 1'b0);

        // 3-beat packet, last beat 3 bytes
        send(0, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0, 64'h8877665544332211, 3'd0, 1'b1, 1'b0);
        send(0, 64'h99AABBCCDDEEFF00, 8'hFF, 1'b0, 1'b1, 64'h00FFEEDDCCBBAA99, 3'd0, 1'b0, 1'b0);
        send(0, 64'h0000000000C0FFEE, 8'h07, 1'b1, 1'b0, 64'hEEFFC00000000000, 3'd5, 1'b0, 1'b0);

        // malformed middle beat -> error on eop, next packet clean
        send(0, 64'h01, 8'hFF, 1'b0, 1'b0, top_byte(8'h01), 3'd0, 1'b1, 1'b0);
        send(0, 64'h02, 8'h7F, 1'b0, 1'b0, top_byte(8'h02), 3'd0, 1'b0, 1'b0);
        send(0, 64'h03, 8'h03, 1'b1, 1'b0, top_byte(8'h03), 3'd6, 1'b0, 1'b1);
        send(0, 64'h04, 8'hFF, 1'b1, 1'b0, top_byte(8'h04), 3'd0, 1'b1, 1'b0);

        // last-beat tkeep boundaries: all-zero, non-contiguous, single byte
        send(0, 64'h05, 8'h00, 1'b1, 1'b1, top_byte(8'h05), 3'd7, 1'b1, 1'b1);
        send(0, 64'h06, 8'h0D, 1'b1, 1'b0, top_byte(8'h06), 3'd4, 1'b1, 1'b1);
        send(0, 64'h07, 8'h01, 1'b1, 1'b1, top_byte(8'h07), 3'd7, 1'b1, 1'b0);
        drain(0);
        chk("mal_pulses_after_T3", 64'(mal_seen0), 64'd3);

        // backpressure: FIFO fills at 4, 5th beat held off, head stays stable
        rdy0 = 1'b0;
        send(0, 64'hB0, 8'hFF, 1'b0, 1'b0, top_byte(8'hB0), 3'd0, 1'b1, 1'b0);
        send(0, 64'hB1, 8'hFF, 1'b0, 1'b1, top_byte(8'hB1), 3'd0, 1'b0, 1'b0);
        send(0, 64'hB2, 8'hFF, 1'b0, 1'b0, top_byte(8'hB2), 3'd0, 1'b0, 1'b0);
        send(0, 64'hB3, 8'hFF, 1'b0, 1'b1, top_byte(8'hB3), 3'd0, 1'b0, 1'b0);
        axis_tvalid[0] = 1'b1;
        axis_tdata[0]  = 64'hB4;
        axis_tkeep[0]  = 8'hFF;
        axis_tlast[0]  = 1'b0;
        axis_tuser[0]  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_tready",    64'(axis_tready[0]), 64'd0);
            chk("held_valid",     64'(avst_valid[0]),  64'd1);
            chk("held_data",      avst_data[0],        top_byte(8'hB0));
            @(posedge clk); #1;
        end
        rdy0 = 1'b1;
        send(0, 64'hB4, 8'hFF, 1'b0, 1'b0, top_byte(8'hB4), 3'd0, 1'b0, 1'b0);
        send(0, 64'hB5, 8'hFF, 1'b1, 1'b1, top_byte(8'hB5), 3'd0, 1'b0, 1'b0);
        drain(0);

        // ready latency 1 with ready toggling every cycle
        tog_en = 1'b1;
        send(1, 64'hC1, 8'hFF, 1'b0, 1'b1, top_byte(8'hC1), 3'd0, 1'b1, 1'b0);
        send(1, 64'hC2, 8'hFF, 1'b0, 1'b0, top_byte(8'hC2), 3'd0, 1'b0, 1'b0);
        send(1, 64'hC3, 8'h3F, 1'b1, 1'b1, top_byte(8'hC3), 3'd2, 1'b0, 1'b0);
        send(1, 64'hC4, 8'hFF, 1'b1, 1'b0, top_byte(8'hC4), 3'd0, 1'b1, 1'b0);
        send(1, 64'hC5, 8'h01, 1'b1, 1'b1, top_byte(8'hC5), 3'd7, 1'b1, 1'b0);
        drain(1);
        tog_en = 1'b0;

        // reset mid-packet after 2 of 4 beats (second one malformed)
        rdy0 = 1'b0;
        send(0, 64'hD0, 8'hFF, 1'b0, 1'b0, top_byte(8'hD0), 3'd0, 1'b1, 1'b0);
        send(0, 64'hD1, 8'h7F, 1'b0, 1'b0, top_byte(8'hD1), 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tready", 64'(axis_tready[0]), 64'd0);
        chk("midrst_valid",  64'(avst_valid[0]),  64'd0);
        chk("midrst_data",   avst_data[0],        64'd0);
        chk("midrst_sop",    64'(avst_sop[0]),    64'd0);
        chk("midrst_empty",  64'(avst_empty[0]),  64'd0);
        chk("midrst_mal",    64'(mal_pulse[0]),   64'd0);
`ifdef ETH_AXIS_AVST_BRIDGE_STATS_EN
        chk("midrst_stat_pkt", 64'(stat_pkt[0]), 64'd0);
        chk("midrst_stat_mal", 64'(stat_mal[0]), 64'd0);
`endif
        q0.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rdy0  = 1'b1;
        send(0, 64'hE0, 8'hFF, 1'b1, 1'b0, top_byte(8'hE0), 3'd0, 1'b1, 1'b0);
        drain(0);

        chk("mal_pulses_dut0", 64'(mal_seen0), 64'd4);
        chk("mal_pulses_dut1", 64'(mal_seen1), 64'd0);
`ifdef ETH_AXIS_AVST_BRIDGE_STATS_EN
        chk("stat_pkt_dut0", 64'(stat_pkt[0]), 64'd1);
        chk("stat_mal_dut0", 64'(stat_mal[0]), 64'd0);
        chk("stat_pkt_dut1", 64'(stat_pkt[1]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
